// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave backed by NUM_REGS memory-mapped registers.
// Write path: W_IDLE -> W_COMMIT -> W_RESP; AW and W are captured independently in W_IDLE.
// Read path: R_IDLE -> R_RESP; read data is registered on the AR handshake.
// Optional build macro AXI4L_REGFILE_SLVERR_EN: out-of-range accesses answer SLVERR
// instead of OKAY. Out-of-range writes are always dropped and reads always return 0.
module axi4_lite_regfile_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY
);
    localparam int NBYTES   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(NBYTES);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam logic [IDX_W:0] NREGS_L = (IDX_W+1)'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4L_REGFILE_SLVERR_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_RESP}           rstate_t;

    wstate_t wstate, w_next;
    rstate_t rstate, r_next;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

    logic              aw_done, w_done;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NBYTES-1:0] wstrb_q;
    logic [1:0]        bresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic [DATA_WIDTH-1:0] rd_mux;

    logic aw_hs, w_hs, ar_hs, w_in_range, r_in_range;
    logic [IDX_W-1:0] ar_idx;

    // Sub-word address bits carry no meaning for whole-register access.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

    assign AWREADY = (wstate == W_IDLE) && !aw_done;
    assign WREADY  = (wstate == W_IDLE) && !w_done;
    assign BVALID  = (wstate == W_RESP);
    assign BRESP   = bresp_q;
    assign ARREADY = (rstate == R_IDLE);
    assign RVALID  = (rstate == R_RESP);
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    assign aw_hs      = AWVALID && AWREADY;
    assign w_hs       = WVALID && WREADY;
    assign ar_hs      = ARVALID && ARREADY;
    assign ar_idx     = ARADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign w_in_range = {1'b0, aw_idx_q} < NREGS_L;
    assign r_in_range = {1'b0, ar_idx} < NREGS_L;

    // Write FSM state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) wstate <= W_IDLE;
        else          wstate <= w_next;
    end

    // Write FSM next state: leave idle once both AW and W are held or arriving.
    always_comb begin
        w_next = wstate;
        case (wstate)
            W_IDLE:   if ((aw_done || aw_hs) && (w_done || w_hs)) w_next = W_COMMIT;
            W_COMMIT: w_next = W_RESP;
            W_RESP:   if (BREADY) w_next = W_IDLE;
            default:  w_next = W_IDLE;
        endcase
    end

    // Capture AW and W independently; flags clear on commit so READY returns after B.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_done  <= 1'b1;
                aw_idx_q <= AWADDR[ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_hs) begin
                w_done  <= 1'b1;
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
            end
            if (wstate == W_COMMIT) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                bresp_q <= w_in_range ? RESP_OKAY : RESP_OOR;
            end
        end
    end

    // Register file: byte-strobed update during the single commit cycle.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            regs <= '0;
        end else if (wstate == W_COMMIT && w_in_range) begin
            for (int i = 0; i < NUM_REGS; i++)
                for (int b = 0; b < NBYTES; b++)
                    if (aw_idx_q == IDX_W'(i) && wstrb_q[b])
                        regs[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
    end

    // Read mux; indices with no register fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (ar_idx == IDX_W'(i)) rd_mux = regs[i];
    end

    // Read FSM state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) rstate <= R_IDLE;
        else          rstate <= r_next;
    end

    // Read FSM next state: one outstanding read, released by the R handshake.
    always_comb begin
        r_next = rstate;
        case (rstate)
            R_IDLE:  if (ARVALID) r_next = R_RESP;
            R_RESP:  if (RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Register read data on the AR handshake; held while RVALID is up.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_mux;
            rresp_q <= r_in_range ? RESP_OKAY : RESP_OOR;
        end
    end
endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Bench for axi4_lite_regfile_slave (default parameters). Inputs change #1 after the
// rising edge; a negedge monitor pops expected B/R beats from scoreboard queues.
module tb_axi4_lite_regfile_slave;
`ifdef AXI4L_REGFILE_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic        ACLK, ARESETn;
    logic [11:0] AWADDR, ARADDR;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    axi4_lite_regfile_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int tests = 0;
    int fails = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [31:0] model[16];
    logic [1:0]  exp_b;
    logic [33:0] exp_r;

    function automatic logic in_range(input logic [11:0] a);
        return a[11:2] < 10'd16;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Scoreboard monitor: every B/R beat must match the oldest pending expectation.
    always @(negedge ACLK) begin
        if (ARESETn && BVALID && BREADY) begin
            tests++;
            if (bq.size() == 0) begin
                fails++;
                $display("FAIL b_unexpected: BRESP=%b with no pending write", BRESP);
            end else begin
                exp_b = bq.pop_front();
                if (BRESP !== exp_b) begin
                    fails++;
                    $display("FAIL bresp: got %b expected %b", BRESP, exp_b);
                end
            end
        end
        if (ARESETn && RVALID && RREADY) begin
            tests++;
            if (rq.size() == 0) begin
                fails++;
                $display("FAIL r_unexpected: RDATA=%h with no pending read", RDATA);
            end else begin
                exp_r = rq.pop_front();
                if ({RRESP, RDATA} !== exp_r) begin
                    fails++;
                    $display("FAIL rdata: got resp=%b data=%h expected resp=%b data=%h",
                             RRESP, RDATA, exp_r[33:32], exp_r[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge ACLK); #1;
    endtask

    task automatic wait_bvalid(input string name);
        int n = 0;
        while (!BVALID && n < 20) begin tick(); n++; end
        if (!BVALID) begin
            tests++; fails++;
            $display("FAIL %s_b_timeout: BVALID=%b expected 1", name, BVALID);
        end
        tick();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        tick();
        AWADDR = a; AWVALID = 1; WDATA = d; WSTRB = s; WVALID = 1;
        bq.push_back(in_range(a) ? 2'b00 : OOR_RESP);
        if (in_range(a)) model[a[5:2]] = merge(model[a[5:2]], d, s);
        while (!(AWREADY && WREADY) && n < 20) begin tick(); n++; end
        if (!(AWREADY && WREADY)) begin
            tests++; fails++;
            $display("FAIL wr_accept_timeout: AWREADY=%b WREADY=%b", AWREADY, WREADY);
        end
        tick();
        AWVALID = 0; WVALID = 0;
        wait_bvalid("wr");
    endtask

    task automatic rd(input logic [11:0] a);
        int n = 0;
        tick();
        ARADDR = a; ARVALID = 1;
        rq.push_back({in_range(a) ? 2'b00 : OOR_RESP, in_range(a) ? model[a[5:2]] : 32'h0});
        while (!ARREADY && n < 20) begin tick(); n++; end
        tick();
        ARVALID = 0;
        n = 0;
        while (!RVALID && n < 20) begin tick(); n++; end
        if (!RVALID) begin
            tests++; fails++;
            $display("FAIL rd_timeout: RVALID=%b expected 1", RVALID);
        end
        tick();
    endtask

    task automatic test_reset();
        ARESETn = 1; #1 ARESETn = 0;
        tick(); tick();
        tests++;
        if ({BVALID, RVALID, BRESP, RRESP} !== 6'b0 || RDATA !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: BV=%b RV=%b BR=%b RR=%b RD=%h expected all 0",
                     BVALID, RVALID, BRESP, RRESP, RDATA);
        end
        tests++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            fails++;
            $display("FAIL reset_ready: AW/W/AR READY=%b%b%b expected 111", AWREADY, WREADY, ARREADY);
        end
        ARESETn = 1;
        tick();
    endtask

    task automatic test_write_read();
        tick();
        AWADDR = 12'h004; AWVALID = 1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1;
        bq.push_back(2'b00);
        model[1] = merge(model[1], 32'hDEADBEEF, 4'hF);
        tests++;
        if (!(AWREADY && WREADY)) begin
            fails++;
            $display("FAIL wr_ready: AWREADY=%b WREADY=%b expected 1 1", AWREADY, WREADY);
        end
        tick();
        AWVALID = 0; WVALID = 0;
        tests++;
        if (BVALID !== 1'b0) begin
            fails++; $display("FAIL bvalid_early: BVALID=%b expected 0", BVALID);
        end
        tick();
        tests++;
        if (BVALID !== 1'b1) begin
            fails++; $display("FAIL bvalid_latency: BVALID=%b expected 1", BVALID);
        end
        tick();
        rd(12'h004);
    endtask

    task automatic test_w_before_aw();
        wr(12'h008, 32'hFFFFFFFF, 4'hF);
        tick();
        WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1; AWVALID = 0;
        bq.push_back(2'b00);
        model[2] = merge(model[2], 32'h11223344, 4'b0101);
        tick();
        WVALID = 0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (WREADY !== 1'b0 || AWREADY !== 1'b1) begin
                fails++;
                $display("FAIL w_wait_ready: cycle %0d WREADY=%b AWREADY=%b expected 0 1", i, WREADY, AWREADY);
            end
            if (i < 2) tick();
        end
        AWADDR = 12'h008; AWVALID = 1;
        tick();
        AWVALID = 0;
        wait_bvalid("w_before_aw");
        rd(12'h008);
    endtask

    task automatic test_b_stall();
        tick();
        BREADY = 0;
        AWADDR = 12'h010; AWVALID = 1; WDATA = 32'h0BADF00D; WSTRB = 4'hF; WVALID = 1;
        bq.push_back(2'b00);
        model[4] = merge(model[4], 32'h0BADF00D, 4'hF);
        tick();
        AWVALID = 0; WVALID = 0;
        tick();
        AWADDR = 12'h014; AWVALID = 1; WDATA = 32'hCAFEBABE; WSTRB = 4'b1100; WVALID = 1;
        bq.push_back(2'b00);
        model[5] = merge(model[5], 32'hCAFEBABE, 4'b1100);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (BVALID !== 1'b1 || BRESP !== 2'b00 || AWREADY !== 1'b0) begin
                fails++;
                $display("FAIL b_stall: cycle %0d BVALID=%b BRESP=%b AWREADY=%b expected 1 00 0",
                         i, BVALID, BRESP, AWREADY);
            end
            tick();
        end
        BREADY = 1;
        tick();
        tests++;
        if (AWREADY !== 1'b1 || WREADY !== 1'b1) begin
            fails++;
            $display("FAIL second_accept: AWREADY=%b WREADY=%b expected 1 1", AWREADY, WREADY);
        end
        tick();
        AWVALID = 0; WVALID = 0;
        wait_bvalid("b_stall");
        rd(12'h010);
        rd(12'h014);
    endtask

    task automatic test_out_of_range();
        rd(12'h040);
        wr(12'h040, 32'hFFFFFFFF, 4'hF);
        rd(12'hFFC);
        for (int i = 0; i < 16; i++) rd(12'(i * 4));
    endtask

    task automatic test_concurrent();
        wr(12'h00C, 32'hA5A5A5A5, 4'hF);
        tick();
        AWADDR = 12'h00C; AWVALID = 1; WDATA = 32'h5A5A5A5A; WSTRB = 4'hF; WVALID = 1;
        bq.push_back(2'b00);
        tick();
        AWVALID = 0; WVALID = 0;
        ARADDR = 12'h00C; ARVALID = 1;
        rq.push_back({2'b00, model[3]});
        model[3] = 32'h5A5A5A5A;
        tick();
        ARVALID = 0;
        tests++;
        if (RVALID !== 1'b1 || BVALID !== 1'b1) begin
            fails++;
            $display("FAIL concurrent_valid: RVALID=%b BVALID=%b expected 1 1", RVALID, BVALID);
        end
        tick();
        rd(12'h00C);
    endtask

    task automatic test_reset_mid();
        tick();
        BREADY = 0; RREADY = 0;
        AWADDR = 12'h018; AWVALID = 1; WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1;
        ARADDR = 12'h004; ARVALID = 1;
        tick();
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        tick();
        tests++;
        if (BVALID !== 1'b1 || RVALID !== 1'b1) begin
            fails++;
            $display("FAIL mid_setup: BVALID=%b RVALID=%b expected 1 1", BVALID, RVALID);
        end
        ARESETn = 0;
        bq.delete(); rq.delete();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        #1;
        tests++;
        if (BVALID !== 1'b0 || RVALID !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_drop: BVALID=%b RVALID=%b expected 0 0", BVALID, RVALID);
        end
        tick();
        ARESETn = 1; BREADY = 1; RREADY = 1;
        tick(); tick(); tick();
        tests++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b11100) begin
            fails++;
            $display("FAIL mid_release: AWR WR ARR BV RV=%b expected 11100",
                     {AWREADY, WREADY, ARREADY, BVALID, RVALID});
        end
        for (int i = 0; i < 16; i++) rd(12'(i * 4));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn = 1; AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0;
        BREADY = 1; ARADDR = 0; ARVALID = 0; RREADY = 1;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        test_reset();
        test_write_read();
        test_w_before_aw();
        test_b_stall();
        test_out_of_range();
        test_concurrent();
        test_reset_mid();
        tick(); tick();
        tests++;
        if (bq.size() != 0 || rq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d B and %0d R beats still expected", bq.size(), rq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
